// File: rtl/int_mul_iterative.sv
// int_mul_iterative: iterative shift-and-add multiplier with val/rdy request
// and response interfaces. One conditional add plus one shift per CALC cycle;
// the result is the low p_nbits bits of a*b (same for signed and unsigned).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   req_val    request valid
//   req_rdy    request ready, high only while idle (registered)
//   req_msg_a  multiplicand, sampled only on the accepting edge
//   req_msg_b  multiplier, sampled only on the accepting edge
//   resp_val   response valid, high only while the result is held (registered)
//   resp_rdy   consumer ready
//   resp_msg   product, low p_nbits bits of a*b (driven straight from acc)
module int_mul_iterative #(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [p_nbits-1:0] req_msg_a,
    input  logic [p_nbits-1:0] req_msg_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_msg
);

    localparam int unsigned CNT_W = $clog2(p_nbits) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] a_nxt;
    logic [p_nbits-1:0] b_reg;
    logic [p_nbits-1:0] b_nxt;
    logic [p_nbits-1:0] acc;
    logic [p_nbits-1:0] acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    // State register; handshake outputs are registered from the next state so
    // they always equal a decode of the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            req_rdy  <= 1'b1;
            resp_val <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_rdy  <= (state_nxt == IDLE);
            resp_val <= (state_nxt == DONE);
        end
    end

    // Next-state and datapath update; every register holds unless told otherwise.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                // req_rdy is high throughout IDLE, so req_val alone accepts.
                if (req_val) begin
                    a_nxt     = req_msg_a;
                    b_nxt     = req_msg_b;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                // Always p_nbits iterations, even once b_reg has drained to zero.
                if (b_reg[0]) begin
                    acc_nxt = acc + a_reg;
                end
                a_nxt   = a_reg << 1;
                b_nxt   = b_reg >> 1;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(p_nbits - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A request arriving here waits until IDLE is reached.
                if (resp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            a_reg <= a_nxt;
            b_reg <= b_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign resp_msg = acc;

endmodule
